// File: rtl/multicycle_ctrl_exc.sv
// Multicycle MIPS control unit with parametrised memory wait states and
// precise exceptions (invalid opcode/funct, arithmetic overflow).
module multicycle_ctrl_exc #(
    parameter int unsigned MEM_LAT = 1,
    parameter logic [31:0] OPC_VEC = 32'h0000_0080,
    parameter logic [31:0] OVF_VEC = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        overflow,
    output logic        PCWrite,
    output logic        IorD,
    output logic        wr,
    output logic        IRWrite,
    output logic        AOWR,
    output logic        AWrite,
    output logic        BWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic        EPCWrite,
    output logic        CauseWrite,
    output logic        cause,
    output logic [31:0] exc_vector,
    output logic [3:0]  Estado
);

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_R_EXEC    = 4'd3,
        ST_R_WB      = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_READ  = 4'd6,
        ST_MEM_WB    = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12,
        ST_EXC       = 4'd13,
        ST_EXC_JUMP  = 4'd14
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd6;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       ovf_q;
    logic       cause_q;
    logic       mem_done;
    logic       funct_ok;
    logic       funct_arith;
    logic [2:0] r_alu_op;

    assign mem_done    = (wait_cnt == LAST_WAIT);
    assign funct_ok    = (funct == FN_ADD) || (funct == FN_SUB) ||
                         (funct == FN_AND) || (funct == FN_XOR);
    assign funct_arith = (funct == FN_ADD) || (funct == FN_SUB);

    always_comb begin
        r_alu_op = OP_ADD;
        case (funct)
            FN_SUB:  r_alu_op = OP_SUB;
            FN_AND:  r_alu_op = OP_AND;
            FN_XOR:  r_alu_op = OP_XOR;
            default: r_alu_op = OP_ADD;
        endcase
    end

    // Wait counter drops to 0 on every transition, so it always starts at 0
    // when a wait state (FETCH, MEM_READ, MEM_WRITE) is entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_RST;
            wait_cnt <= 4'd0;
            ovf_q    <= 1'b0;
            cause_q  <= 1'b0;
        end else begin
            wait_cnt <= 4'd0;
            case (state)
                ST_RST: state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_done) state <= ST_DECODE;
                    else          wait_cnt <= wait_cnt + 4'd1;
                end
                ST_DECODE: begin
                    if (opcode == OPC_RTYPE && funct_ok)         state <= ST_R_EXEC;
                    else if (opcode == OPC_LW || opcode == OPC_SW) state <= ST_MEM_ADDR;
                    else if (opcode == OPC_BEQ)                  state <= ST_BRANCH;
                    else if (opcode == OPC_J)                    state <= ST_JUMP;
                    else if (opcode == OPC_ADDI)                 state <= ST_ADDI_EXEC;
                    else begin
                        state   <= ST_EXC;
                        cause_q <= 1'b0;
                    end
                end
                ST_R_EXEC: begin
                    ovf_q <= funct_arith ? overflow : 1'b0;
                    state <= ST_R_WB;
                end
                ST_ADDI_EXEC: begin
                    ovf_q <= overflow;
                    state <= ST_ADDI_WB;
                end
                ST_R_WB, ST_ADDI_WB: begin
                    if (ovf_q) begin
                        state   <= ST_EXC;
                        cause_q <= 1'b1;
                    end else begin
                        state <= ST_FETCH;
                    end
                end
                ST_MEM_ADDR: state <= (opcode == OPC_LW) ? ST_MEM_READ : ST_MEM_WRITE;
                ST_MEM_READ: begin
                    if (mem_done) state <= ST_MEM_WB;
                    else          wait_cnt <= wait_cnt + 4'd1;
                end
                ST_MEM_WRITE: begin
                    if (mem_done) state <= ST_FETCH;
                    else          wait_cnt <= wait_cnt + 4'd1;
                end
                ST_MEM_WB, ST_BRANCH, ST_JUMP, ST_EXC_JUMP: state <= ST_FETCH;
                ST_EXC:  state <= ST_EXC_JUMP;
                default: state <= ST_RST;
            endcase
        end
    end

    // Moore decode; only BRANCH looks at an input (zero gates PCWrite).
    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        wr         = 1'b0;
        IRWrite    = 1'b0;
        AOWR       = 1'b0;
        AWrite     = 1'b0;
        BWrite     = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'd0;
        ALUOp      = 3'd0;
        PCSource   = 2'd0;
        EPCWrite   = 1'b0;
        CauseWrite = 1'b0;
        case (state)
            ST_FETCH: begin
                if (mem_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'd1;
                    ALUOp   = OP_ADD;
                end
            end
            ST_DECODE: begin
                AWrite  = 1'b1;
                BWrite  = 1'b1;
                AOWR    = 1'b1;
                ALUSrcB = 2'd3;
                ALUOp   = OP_ADD;
            end
            ST_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = r_alu_op;
            end
            ST_R_WB: begin
                ALUSrcA = 1'b1;
                ALUOp   = r_alu_op;
                if (!ovf_q) begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
            end
            ST_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUOp   = OP_ADD;
            end
            ST_ADDI_WB: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'd2;
                ALUOp    = OP_ADD;
                RegWrite = !ovf_q;
            end
            ST_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUOp   = OP_ADD;
                AOWR    = 1'b1;
            end
            ST_MEM_READ: IorD = 1'b1;
            ST_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEM_WRITE: begin
                IorD = 1'b1;
                wr   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = OP_SUB;
                PCSource = 2'd1;
                PCWrite  = zero;
            end
            ST_JUMP: begin
                PCSource = 2'd2;
                PCWrite  = 1'b1;
            end
            ST_EXC: begin
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                ALUSrcB    = 2'd1;
                ALUOp      = OP_SUB;
            end
            ST_EXC_JUMP: begin
                PCSource = 2'd3;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign cause      = cause_q;
    assign exc_vector = cause_q ? OVF_VEC : OPC_VEC;
    assign Estado     = state;

endmodule

// File: tb/tb_multicycle_ctrl_exc.sv
// Directed bench for multicycle_ctrl_exc: three instances with MEM_LAT 1, 3
// and 4, exercised one at a time while the others are held in reset.
module tb_multicycle_ctrl_exc;

    logic        clock;
    logic [2:0]  rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        overflow;

    logic [2:0]  pc_write, ior_d, wr, ir_write, aowr, a_write, b_write;
    logic [2:0]  reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [2:0]  epc_write, cause_write, cause;
    logic [1:0]  alu_src_b  [3];
    logic [2:0]  alu_op     [3];
    logic [1:0]  pc_source  [3];
    logic [31:0] exc_vector [3];
    logic [3:0]  estado     [3];

    int sel;
    int check_count;
    int error_count;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        multicycle_ctrl_exc #(.MEM_LAT(LAT)) dut (
            .clock(clock), .reset(rst[g]),
            .opcode(opcode), .funct(funct), .zero(zero), .overflow(overflow),
            .PCWrite(pc_write[g]), .IorD(ior_d[g]), .wr(wr[g]),
            .IRWrite(ir_write[g]), .AOWR(aowr[g]), .AWrite(a_write[g]),
            .BWrite(b_write[g]), .RegDst(reg_dst[g]), .MemtoReg(mem_to_reg[g]),
            .RegWrite(reg_write[g]), .ALUSrcA(alu_src_a[g]),
            .ALUSrcB(alu_src_b[g]), .ALUOp(alu_op[g]), .PCSource(pc_source[g]),
            .EPCWrite(epc_write[g]), .CauseWrite(cause_write[g]),
            .cause(cause[g]), .exc_vector(exc_vector[g]), .Estado(estado[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe word: {PCWrite,IorD,wr,IRWrite,AOWR,AWrite,BWrite,RegDst,MemtoReg,
    // RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[2:0],PCSource[1:0],EPCWrite,CauseWrite}
    localparam logic [19:0] S_PCW  = 20'h80000;
    localparam logic [19:0] S_IORD = 20'h40000;
    localparam logic [19:0] S_WR   = 20'h20000;
    localparam logic [19:0] S_IRW  = 20'h10000;
    localparam logic [19:0] S_AOWR = 20'h08000;
    localparam logic [19:0] S_AW   = 20'h04000;
    localparam logic [19:0] S_BW   = 20'h02000;
    localparam logic [19:0] S_RD   = 20'h01000;
    localparam logic [19:0] S_MTR  = 20'h00800;
    localparam logic [19:0] S_RW   = 20'h00400;
    localparam logic [19:0] S_SA   = 20'h00200;
    localparam logic [19:0] S_EPC  = 20'h00002;
    localparam logic [19:0] S_CW   = 20'h00001;

    function automatic logic [19:0] srcb(input logic [1:0] v);
        return 20'(v) << 7;
    endfunction

    function automatic logic [19:0] aop(input logic [2:0] v);
        return 20'(v) << 4;
    endfunction

    function automatic logic [19:0] pcs(input logic [1:0] v);
        return 20'(v) << 2;
    endfunction

    function automatic logic [19:0] obs(input int i);
        return {pc_write[i], ior_d[i], wr[i], ir_write[i], aowr[i], a_write[i],
                b_write[i], reg_dst[i], mem_to_reg[i], reg_write[i], alu_src_a[i],
                alu_src_b[i], alu_op[i], pc_source[i], epc_write[i], cause_write[i]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic ov);
        opcode   = op;
        funct    = fn;
        zero     = z;
        overflow = ov;
    endtask

    // One clock cycle: compare state and strobes at the falling edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [19:0] sb);
        @(negedge clock);
        checkOutput({tag, ".state"}, 32'(estado[sel]), 32'(st));
        checkOutput({tag, ".strobes"}, 32'(obs(sel)), 32'(sb));
    endtask

    task automatic start(input int i);
        rst = 3'b111;
        sel = i;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset.state", 32'(estado[i]), 32'd0);
        checkOutput("reset.strobes", 32'(obs(i)), 32'd0);
        checkOutput("reset.vector", exc_vector[i], 32'h80);
        checkOutput("reset.cause", 32'(cause[i]), 32'd0);
        rst[i] = 1'b0;
        cyc("rst_cycle", 4'd0, 20'd0);
    endtask

    logic [19:0] fetch_last, decode_sb, exc_sb, exc_jump_sb;

    initial begin
        check_count = 0;
        error_count = 0;
        rst = 3'b111;
        sel = 0;
        applyStimulus(6'h00, 6'h20, 1'b0, 1'b0);
        fetch_last  = S_PCW | S_IRW | srcb(2'd1) | aop(3'd1);
        decode_sb   = S_AW | S_BW | S_AOWR | srcb(2'd3) | aop(3'd1);
        exc_sb      = S_EPC | S_CW | srcb(2'd1) | aop(3'd2);
        exc_jump_sb = S_PCW | pcs(2'd3);

        // MEM_LAT = 1: every wait state collapses to a single cycle
        start(0);
        applyStimulus(6'h00, 6'h20, 1'b0, 1'b0);
        cyc("add.fetch", 4'd1, fetch_last);
        cyc("add.decode", 4'd2, decode_sb);
        cyc("add.exec", 4'd3, S_SA | aop(3'd1));
        cyc("add.wb", 4'd4, S_SA | aop(3'd1) | S_RD | S_RW);

        applyStimulus(6'h04, 6'h00, 1'b1, 1'b0);
        cyc("beq1.fetch", 4'd1, fetch_last);
        cyc("beq1.decode", 4'd2, decode_sb);
        cyc("beq1.branch", 4'd9, S_SA | aop(3'd2) | pcs(2'd1) | S_PCW);

        applyStimulus(6'h04, 6'h00, 1'b0, 1'b0);
        cyc("beq0.fetch", 4'd1, fetch_last);
        cyc("beq0.decode", 4'd2, decode_sb);
        cyc("beq0.branch", 4'd9, S_SA | aop(3'd2) | pcs(2'd1));

        applyStimulus(6'h02, 6'h00, 1'b0, 1'b0);
        cyc("j.fetch", 4'd1, fetch_last);
        cyc("j.decode", 4'd2, decode_sb);
        cyc("j.jump", 4'd10, S_PCW | pcs(2'd2));

        applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0);
        cyc("badop.fetch", 4'd1, fetch_last);
        cyc("badop.decode", 4'd2, decode_sb);
        cyc("badop.exc", 4'd13, exc_sb);
        checkOutput("badop.cause", 32'(cause[0]), 32'd0);
        cyc("badop.excjump", 4'd14, exc_jump_sb);
        checkOutput("badop.vector", exc_vector[0], 32'h80);

        applyStimulus(6'h08, 6'h00, 1'b0, 1'b1);
        cyc("addiovf.fetch", 4'd1, fetch_last);
        cyc("addiovf.decode", 4'd2, decode_sb);
        cyc("addiovf.exec", 4'd11, S_SA | srcb(2'd2) | aop(3'd1));
        cyc("addiovf.wb", 4'd12, S_SA | srcb(2'd2) | aop(3'd1));
        cyc("addiovf.exc", 4'd13, exc_sb);
        checkOutput("addiovf.cause", 32'(cause[0]), 32'd1);
        cyc("addiovf.excjump", 4'd14, exc_jump_sb);
        checkOutput("addiovf.vector", exc_vector[0], 32'h100);

        applyStimulus(6'h00, 6'h22, 1'b0, 1'b1);
        cyc("subovf.fetch", 4'd1, fetch_last);
        cyc("subovf.decode", 4'd2, decode_sb);
        cyc("subovf.exec", 4'd3, S_SA | aop(3'd2));
        cyc("subovf.wb", 4'd4, S_SA | aop(3'd2));
        cyc("subovf.exc", 4'd13, exc_sb);
        cyc("subovf.excjump", 4'd14, exc_jump_sb);
        checkOutput("subovf.vector", exc_vector[0], 32'h100);

        // AND ignores the overflow flag and clears the one left by SUB
        applyStimulus(6'h00, 6'h24, 1'b0, 1'b1);
        cyc("and.fetch", 4'd1, fetch_last);
        cyc("and.decode", 4'd2, decode_sb);
        cyc("and.exec", 4'd3, S_SA | aop(3'd3));
        cyc("and.wb", 4'd4, S_SA | aop(3'd3) | S_RD | S_RW);

        applyStimulus(6'h08, 6'h00, 1'b0, 1'b0);
        cyc("addi.fetch", 4'd1, fetch_last);
        cyc("addi.decode", 4'd2, decode_sb);
        cyc("addi.exec", 4'd11, S_SA | srcb(2'd2) | aop(3'd1));
        cyc("addi.wb", 4'd12, S_SA | srcb(2'd2) | aop(3'd1) | S_RW);

        applyStimulus(6'h00, 6'h21, 1'b0, 1'b0);
        cyc("badfn.fetch", 4'd1, fetch_last);
        cyc("badfn.decode", 4'd2, decode_sb);
        cyc("badfn.exc", 4'd13, exc_sb);
        checkOutput("badfn.cause", 32'(cause[0]), 32'd0);
        cyc("badfn.excjump", 4'd14, exc_jump_sb);
        checkOutput("badfn.vector", exc_vector[0], 32'h80);

        // MEM_LAT = 3: lw then sw
        start(1);
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
        cyc("lw.fetch0", 4'd1, 20'd0);
        cyc("lw.fetch1", 4'd1, 20'd0);
        cyc("lw.fetch2", 4'd1, fetch_last);
        cyc("lw.decode", 4'd2, decode_sb);
        cyc("lw.addr", 4'd5, S_SA | srcb(2'd2) | aop(3'd1) | S_AOWR);
        cyc("lw.read0", 4'd6, S_IORD);
        cyc("lw.read1", 4'd6, S_IORD);
        cyc("lw.read2", 4'd6, S_IORD);
        cyc("lw.wb", 4'd7, S_MTR | S_RW);

        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
        cyc("sw.fetch0", 4'd1, 20'd0);
        cyc("sw.fetch1", 4'd1, 20'd0);
        cyc("sw.fetch2", 4'd1, fetch_last);
        cyc("sw.decode", 4'd2, decode_sb);
        cyc("sw.addr", 4'd5, S_SA | srcb(2'd2) | aop(3'd1) | S_AOWR);
        cyc("sw.write0", 4'd8, S_IORD | S_WR);
        cyc("sw.write1", 4'd8, S_IORD | S_WR);
        cyc("sw.write2", 4'd8, S_IORD | S_WR);
        cyc("sw.next", 4'd1, 20'd0);

        // MEM_LAT = 4: asynchronous reset in the middle of MEM_WRITE
        start(2);
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0);
        cyc("sw4.fetch0", 4'd1, 20'd0);
        cyc("sw4.fetch1", 4'd1, 20'd0);
        cyc("sw4.fetch2", 4'd1, 20'd0);
        cyc("sw4.fetch3", 4'd1, fetch_last);
        cyc("sw4.decode", 4'd2, decode_sb);
        cyc("sw4.addr", 4'd5, S_SA | srcb(2'd2) | aop(3'd1) | S_AOWR);
        cyc("sw4.write0", 4'd8, S_IORD | S_WR);
        cyc("sw4.write1", 4'd8, S_IORD | S_WR);
        #2;
        rst[2] = 1'b1;
        #1;
        checkOutput("async.wr", 32'(wr[2]), 32'd0);
        checkOutput("async.state", 32'(estado[2]), 32'd0);
        checkOutput("async.strobes", 32'(obs(2)), 32'd0);
        @(posedge clock);
        #1;
        rst[2] = 1'b0;
        cyc("async.rst_cycle", 4'd0, 20'd0);
        cyc("async.fetch", 4'd1, 20'd0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_exc.md
# multicycle_ctrl_exc

Parametrised multicycle control unit for the MIPS datapath: the successor to the fixed-timing control unit. It sequences fetch/decode/execute/memory/write-back through a Moore FSM and generates every datapath strobe. It adds two capabilities: memory wait states set by a parameter, and precise exception handling (invalid opcode/funct, arithmetic overflow) with EPC/cause capture and a vectored PC load.

## Interface
Parameters:
- MEM_LAT, 1: cycles the address must be held before memory data is valid; legal range 1..15.
- OPC_VEC, 32'h0000_0080: PC loaded on an invalid opcode/funct exception.
- OVF_VEC, 32'h0000_0100: PC loaded on an overflow exception.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- PCWrite, IorD, wr, IRWrite, AOWR, AWrite, BWrite, RegDst, MemtoReg, RegWrite  out  1 each  datapath strobes
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  0=B, 1=const 4, 2=sign-ext, 3=sign-ext<<2
- ALUOp  out  3  LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NEG=5, XOR=6, COMP=7
- PCSource  out  2  0=Alu, 1=AluOut, 2=jump address, 3=exc_vector
- EPCWrite, CauseWrite  out  1 each  exception register strobes
- cause  out  1  0=opcode, 1=overflow
- exc_vector  out  32  OPC_VEC or OVF_VEC, selected by cause
- Estado  out  4  current state encoding, for debug

## Operation
- States and encodings: RST=0, FETCH=1, DECODE=2, R_EXEC=3, R_WB=4, MEM_ADDR=5, MEM_READ=6, MEM_WB=7, MEM_WRITE=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, EXC=13, EXC_JUMP=14.
- Outputs are decoded from state and wait counter only. The single exception: PCWrite in BRANCH equals zero.
- Every strobe not listed for a state is 0. ALUSrcA, ALUSrcB, ALUOp and PCSource default to 0.
- RST: all strobes 0. Next state is FETCH.
- FETCH: IorD=0, wr=0 for MEM_LAT cycles; the wait counter runs 0..MEM_LAT-1. On the last cycle: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, PCSource=0. Next state is DECODE.
- DECODE: AWrite=1, BWrite=1, AOWR=1, ALUSrcA=0, ALUSrcB=3, ALUOp=ADD (branch target). Dispatch:
  - opcode 0x00 with funct in {0x20, 0x22, 0x24, 0x26} → R_EXEC
  - opcode 0x23 or 0x2B → MEM_ADDR
  - opcode 0x04 → BRANCH
  - opcode 0x02 → JUMP
  - opcode 0x08 → ADDI_EXEC
  - anything else → EXC with cause=0
- R_EXEC: ALUSrcA=1, ALUSrcB=0. ALUOp by funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR. The overflow input is registered into ovf_q only for ADD/SUB; AND/XOR clear ovf_q. Next state is R_WB.
- R_WB: ALU selects and ALUOp held as in R_EXEC. If ovf_q=1, no RegWrite and go to EXC with cause=1. Otherwise RegDst=1, MemtoReg=0, RegWrite=1, then FETCH.
- ADDI_EXEC / ADDI_WB: same pattern with ALUSrcB=2, ALUOp=ADD, RegDst=0.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=ADD, AOWR=1. Next state is MEM_READ for opcode 0x23, MEM_WRITE for 0x2B.
- MEM_READ: IorD=1 for MEM_LAT cycles (MDR latches every cycle). Next state is MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next state is FETCH.
- MEM_WRITE: IorD=1, wr=1 for MEM_LAT cycles. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCSource=1, PCWrite=zero. Next state is FETCH.
- JUMP: PCSource=2, PCWrite=1. Next state is FETCH.
- EXC: EPCWrite=1, CauseWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=SUB (EPC ← PC−4, the faulting instruction). Next state is EXC_JUMP.
- EXC_JUMP: PCSource=3, PCWrite=1. Next state is FETCH.
- The cause register is internal. It is set in DECODE (→0) or R_WB/ADDI_WB (→1) and drives both the cause and exc_vector outputs.

## Timing
- Reset: state=RST, wait counter=0, ovf_q=0, cause=0. All strobes are 0, Estado=0, exc_vector=OPC_VEC.
- Reset is asynchronous. Assertion mid-instruction forces RST in the same cycle, so no further strobes occur.
- Instruction latencies, counted from the first FETCH cycle to the last cycle before the next FETCH:
  - R-type / addi: MEM_LAT+3
  - lw: 2·MEM_LAT+3
  - sw: 2·MEM_LAT+2
  - beq / j: MEM_LAT+2
  - invalid opcode: MEM_LAT+3
  - overflow: MEM_LAT+5
- The wait counter resets to 0 on every entry to FETCH, MEM_READ or MEM_WRITE. It never wraps past MEM_LAT-1.
- With MEM_LAT=1, wait states collapse to one cycle each. Verify this boundary explicitly.

## Test plan
- MEM_LAT=1, opcode 0x00 funct 0x20, overflow=0 → state sequence 1,2,3,4,1; RegWrite=1 with RegDst=1 only in state 4; 4 cycles total.
- MEM_LAT=3, opcode 0x23 → FETCH for 3 cycles (IRWrite only on the 3rd), MEM_READ for 3 cycles with IorD=1, then MEM_WB with MemtoReg=1; 9 cycles total.
- opcode 0x04: with zero=1 → PCWrite=1 and PCSource=1 in BRANCH; with zero=0 → PCWrite=0.
- opcode 0x3F → DECODE→EXC (EPCWrite=1, CauseWrite=1, cause=0) → EXC_JUMP (PCSource=3, exc_vector=32'h80, PCWrite=1) → FETCH.
- opcode 0x08 with overflow=1 in ADDI_EXEC → no RegWrite in ADDI_WB; EXC with cause=1; exc_vector=32'h100.
- Assert reset during MEM_WRITE (wr=1) with MEM_LAT=4 → wr drops immediately, Estado=0; after deassert, one RST cycle then FETCH.
